// File: rtl/time_keeper_pkg.sv
// time_keeper_pkg: shared widths, BCD field limits and prescaler sizing helper
// for the time_keeper timekeeping core.
package time_keeper_pkg;

  localparam int DIGIT_W = 4;
  localparam int FIELD_W = 8;

  localparam logic [FIELD_W-1:0] SEC_MAX = 8'h59;
  localparam logic [FIELD_W-1:0] MIN_MAX = 8'h59;
  localparam logic [FIELD_W-1:0] HR_MAX  = 8'h23;

  // Bits needed for a counter running 0..modulus-1; never narrower than one bit.
  function automatic int presc_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/time_keeper_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter that wraps from MAX_BCD to 00.
// o_carry is combinational so a chain of these advances on a single edge.
module bcd_mod_counter
  import time_keeper_pkg::*;
#(
  parameter logic [FIELD_W-1:0] MAX_BCD = SEC_MAX
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_ena,
  output logic [FIELD_W-1:0] o_bcd,
  output logic               o_carry
);

  logic [DIGIT_W-1:0] units;
  logic [DIGIT_W-1:0] tens;
  logic               at_max;
  logic [FIELD_W-1:0] next_bcd;

  assign units   = o_bcd[DIGIT_W-1:0];
  assign tens    = o_bcd[FIELD_W-1:DIGIT_W];
  assign at_max  = (o_bcd == MAX_BCD);
  assign o_carry = i_ena & at_max;

  // Next BCD value: units 0-9 carry into tens, whole field wraps at MAX_BCD.
  always_comb begin
    next_bcd = o_bcd;
    if (at_max) begin
      next_bcd = '0;
    end else if (units == 4'd9) begin
      next_bcd = {tens + 4'd1, 4'd0};
    end else begin
      next_bcd = {tens, units + 4'd1};
    end
  end

  // Field register: clear wins over enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bcd <= '0;
    end else if (i_clr) begin
      o_bcd <= '0;
    end else if (i_ena) begin
      o_bcd <= next_bcd;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: divides i_clk into a 1 Hz strobe and a display-scan strobe and
// keeps BCD time of day (hh:mm:ss).
// Build option TIME_KEEPER_SET_EN: when defined, i_set_min / i_set_hr advance
// minutes / hours; otherwise those ports are ignored.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run,
  input  logic               i_clear,
  input  logic               i_set_min,
  input  logic               i_set_hr,
  output logic               o_tick_1hz,
  output logic               o_tick_scan,
  output logic [FIELD_W-1:0] o_sec_bcd,
  output logic [FIELD_W-1:0] o_min_bcd,
  output logic [FIELD_W-1:0] o_hr_bcd,
  output logic               o_rollover
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int W_1HZ    = presc_width(CLK_HZ);
  localparam int W_SCAN   = presc_width(SCAN_DIV);

  localparam logic [W_1HZ-1:0]  LAST_1HZ  = W_1HZ'(CLK_HZ - 1);
  localparam logic [W_SCAN-1:0] LAST_SCAN = W_SCAN'(SCAN_DIV - 1);

  logic [W_1HZ-1:0]  cnt_1hz;
  logic [W_SCAN-1:0] cnt_scan;
  logic              wrap_1hz;
  logic              wrap_scan;

  logic set_min;
  logic set_hr;

  logic sec_carry;
  logic min_carry;
  logic hr_carry;
  logic min_to_hr;
  logic day_wrap;

`ifdef TIME_KEEPER_SET_EN
  assign set_min = i_set_min;
  assign set_hr  = i_set_hr;
`else
  logic unused_set;
  assign set_min    = 1'b0;
  assign set_hr     = 1'b0;
  assign unused_set = i_set_min ^ i_set_hr;
`endif

  assign wrap_1hz  = i_run & (cnt_1hz == LAST_1HZ);
  assign wrap_scan = i_run & (cnt_scan == LAST_SCAN);

  // 1 Hz prescaler: frozen while i_run is low, resumes from the held count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_1hz <= '0;
    end else if (i_clear) begin
      cnt_1hz <= '0;
    end else if (i_run) begin
      cnt_1hz <= wrap_1hz ? '0 : cnt_1hz + W_1HZ'(1);
    end
  end

  // Scan prescaler: same scheme, untouched by time-set pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_scan <= '0;
    end else if (i_clear) begin
      cnt_scan <= '0;
    end else if (i_run) begin
      cnt_scan <= wrap_scan ? '0 : cnt_scan + W_SCAN'(1);
    end
  end

  // Hours only follow a counting carry: a set pulse on minutes 59 reports
  // o_carry from the minutes counter, so it is masked with the seconds carry.
  assign min_to_hr = min_carry & sec_carry;
  assign day_wrap  = hr_carry & min_to_hr;

  bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_sec (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clear),
    .i_ena   (wrap_1hz),
    .o_bcd   (o_sec_bcd),
    .o_carry (sec_carry)
  );

  bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_min (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clear),
    .i_ena   (sec_carry | set_min),
    .o_bcd   (o_min_bcd),
    .o_carry (min_carry)
  );

  bcd_mod_counter #(.MAX_BCD(HR_MAX)) u_hr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clear),
    .i_ena   (min_to_hr | set_hr),
    .o_bcd   (o_hr_bcd),
    .o_carry (hr_carry)
  );

  // Registered strobes, aligned with the edge that updates the time fields.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tick_1hz  <= 1'b0;
      o_tick_scan <= 1'b0;
      o_rollover  <= 1'b0;
    end else if (i_clear) begin
      o_tick_1hz  <= 1'b0;
      o_tick_scan <= 1'b0;
      o_rollover  <= 1'b0;
    end else begin
      o_tick_1hz  <= wrap_1hz;
      o_tick_scan <= wrap_scan;
      o_rollover  <= day_wrap;
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed bench for time_keeper with CLK_HZ=10, SCAN_HZ=5.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_time_keeper;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       run      = 1'b0;
  logic       clear    = 1'b0;
  logic       set_min  = 1'b0;
  logic       set_hr   = 1'b0;
  logic       tick_1hz;
  logic       tick_scan;
  logic       rollover;
  logic [7:0] sec;
  logic [7:0] mn;
  logic [7:0] hr;

  int n_assert = 0;
  int n_fail   = 0;

  time_keeper #(.CLK_HZ(10), .SCAN_HZ(5)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_run       (run),
    .i_clear     (clear),
    .i_set_min   (set_min),
    .i_set_hr    (set_hr),
    .o_tick_1hz  (tick_1hz),
    .o_tick_scan (tick_scan),
    .o_sec_bcd   (sec),
    .o_min_bcd   (mn),
    .o_hr_bcd    (hr),
    .o_rollover  (rollover)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++; if (tick_1hz !== 1'b0) begin n_fail++; $display("FAIL reset_tick_1hz got %b exp 0", tick_1hz); end
    n_assert++; if (tick_scan !== 1'b0) begin n_fail++; $display("FAIL reset_tick_scan got %b exp 0", tick_scan); end
    n_assert++; if (rollover !== 1'b0) begin n_fail++; $display("FAIL reset_rollover got %b exp 0", rollover); end
    n_assert++; if (sec !== 8'h00) begin n_fail++; $display("FAIL reset_sec got %h exp 00", sec); end
    n_assert++; if (mn !== 8'h00) begin n_fail++; $display("FAIL reset_min got %h exp 00", mn); end
    n_assert++; if (hr !== 8'h00) begin n_fail++; $display("FAIL reset_hr got %h exp 00", hr); end
    rst_n = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      logic exp_t;
      logic exp_s;
      step();
      exp_t = (c % 10 == 0);
      exp_s = (c % 2 == 0);
      n_assert++; if (tick_1hz !== exp_t) begin n_fail++; $display("FAIL start_tick_1hz cyc %0d got %b exp %b", c, tick_1hz, exp_t); end
      n_assert++; if (tick_scan !== exp_s) begin n_fail++; $display("FAIL start_tick_scan cyc %0d got %b exp %b", c, tick_scan, exp_s); end
      n_assert++; if (sec !== bcd(c / 10)) begin n_fail++; $display("FAIL start_sec cyc %0d got %h exp %h", c, sec, bcd(c / 10)); end
    end
  endtask

  task automatic test_sec_min_carry();
    do_clear();
    for (int c = 1; c <= 600; c++) begin
      step();
      n_assert++; if (sec !== bcd((c / 10) % 60)) begin n_fail++; $display("FAIL carry_sec cyc %0d got %h exp %h", c, sec, bcd((c / 10) % 60)); end
      n_assert++; if (mn !== bcd(c / 600)) begin n_fail++; $display("FAIL carry_min cyc %0d got %h exp %h", c, mn, bcd(c / 600)); end
      n_assert++; if (tick_1hz !== (c % 10 == 0)) begin n_fail++; $display("FAIL carry_tick cyc %0d got %b", c, tick_1hz); end
    end
    n_assert++; if (hr !== 8'h00) begin n_fail++; $display("FAIL carry_hr got %h exp 00", hr); end
  endtask

  task automatic test_hour_carry();
    int rollover_seen = 0;
    for (int c = 601; c <= 36000; c++) begin
      step();
      if (rollover !== 1'b0) rollover_seen++;
      if (c % 10 == 0) begin
        int s;
        s = c / 10;
        n_assert++; if ({hr, mn, sec} !== {bcd(s / 3600), bcd((s / 60) % 60), bcd(s % 60)}) begin
          n_fail++; $display("FAIL hour_time cyc %0d got %h:%h:%h exp %h:%h:%h", c, hr, mn, sec, bcd(s / 3600), bcd((s / 60) % 60), bcd(s % 60));
        end
      end
    end
    n_assert++; if (rollover_seen !== 0) begin n_fail++; $display("FAIL hour_no_rollover got %0d strobes exp 0", rollover_seen); end
  endtask

  task automatic test_run_pause();
    do_clear();
    repeat (13) step();
    n_assert++; if (sec !== 8'h01) begin n_fail++; $display("FAIL pause_pre_sec got %h exp 01", sec); end
    run = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      step();
      n_assert++; if (tick_1hz !== 1'b0 || tick_scan !== 1'b0) begin n_fail++; $display("FAIL pause_strobe cyc %0d got %b%b exp 00", i, tick_1hz, tick_scan); end
      n_assert++; if (sec !== 8'h01) begin n_fail++; $display("FAIL pause_sec cyc %0d got %h exp 01", i, sec); end
    end
    run = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      n_assert++; if (tick_1hz !== (c == 7)) begin n_fail++; $display("FAIL resume_tick cyc %0d got %b", c, tick_1hz); end
      n_assert++; if (tick_scan !== (c % 2 == 1)) begin n_fail++; $display("FAIL resume_scan cyc %0d got %b", c, tick_scan); end
      n_assert++; if (sec !== ((c == 7) ? 8'h02 : 8'h01)) begin n_fail++; $display("FAIL resume_sec cyc %0d got %h", c, sec); end
    end
  endtask

  task automatic test_reset_clear_mid();
    do_clear();
    repeat (20) step();
    n_assert++; if (tick_1hz !== 1'b1 || sec !== 8'h02) begin n_fail++; $display("FAIL mid_pre got tick %b sec %h exp 1 02", tick_1hz, sec); end
    rst_n = 1'b0;
    #1;
    n_assert++; if ({tick_1hz, tick_scan, rollover} !== 3'b000) begin n_fail++; $display("FAIL async_reset_strobes got %b exp 000", {tick_1hz, tick_scan, rollover}); end
    n_assert++; if ({hr, mn, sec} !== 24'h000000) begin n_fail++; $display("FAIL async_reset_time got %h exp 000000", {hr, mn, sec}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      n_assert++; if (tick_1hz !== (c == 10)) begin n_fail++; $display("FAIL post_reset_tick cyc %0d got %b", c, tick_1hz); end
    end
    n_assert++; if (sec !== 8'h01) begin n_fail++; $display("FAIL post_reset_sec got %h exp 01", sec); end
    repeat (10) step();
    clear   = 1'b1;
    set_min = 1'b1;
    set_hr  = 1'b1;
    #1;
    n_assert++; if (sec !== 8'h02 || tick_1hz !== 1'b1) begin n_fail++; $display("FAIL clear_not_immediate got sec %h tick %b exp 02 1", sec, tick_1hz); end
    step();
    clear   = 1'b0;
    set_min = 1'b0;
    set_hr  = 1'b0;
    n_assert++; if ({hr, mn, sec} !== 24'h000000) begin n_fail++; $display("FAIL clear_time got %h exp 000000", {hr, mn, sec}); end
    n_assert++; if ({tick_1hz, tick_scan, rollover} !== 3'b000) begin n_fail++; $display("FAIL clear_strobes got %b exp 000", {tick_1hz, tick_scan, rollover}); end
    for (int c = 1; c <= 10; c++) begin
      step();
      n_assert++; if (tick_1hz !== (c == 10)) begin n_fail++; $display("FAIL post_clear_tick cyc %0d got %b", c, tick_1hz); end
    end
  endtask

`ifdef TIME_KEEPER_SET_EN
  task automatic test_set_wrap();
    run = 1'b0;
    do_clear();
    set_min = 1'b1;
    repeat (59) step();
    set_min = 1'b0;
    n_assert++; if ({hr, mn, sec} !== 24'h005900) begin n_fail++; $display("FAIL set_min59 got %h exp 005900", {hr, mn, sec}); end
    set_min = 1'b1;
    step();
    set_min = 1'b0;
    n_assert++; if ({hr, mn, sec} !== 24'h000000) begin n_fail++; $display("FAIL set_min_wrap got %h exp 000000", {hr, mn, sec}); end
    set_hr = 1'b1;
    repeat (3) step();
    set_hr = 1'b0;
    n_assert++; if (hr !== 8'h03) begin n_fail++; $display("FAIL set_hr_held got %h exp 03", hr); end
    set_hr = 1'b1;
    repeat (20) step();
    set_hr = 1'b0;
    n_assert++; if (hr !== 8'h23) begin n_fail++; $display("FAIL set_hr23 got %h exp 23", hr); end
    set_hr = 1'b1;
    step();
    set_hr = 1'b0;
    n_assert++; if (hr !== 8'h00 || rollover !== 1'b0) begin n_fail++; $display("FAIL set_hr_wrap got hr %h roll %b exp 00 0", hr, rollover); end
  endtask

  task automatic test_rollover();
    run = 1'b0;
    do_clear();
    set_hr = 1'b1;
    repeat (23) step();
    set_hr  = 1'b0;
    set_min = 1'b1;
    repeat (59) step();
    set_min = 1'b0;
    run = 1'b1;
    repeat (590) step();
    n_assert++; if ({hr, mn, sec} !== 24'h235959) begin n_fail++; $display("FAIL preload got %h exp 235959", {hr, mn, sec}); end
    for (int c = 1; c <= 10; c++) begin
      step();
      n_assert++; if (rollover !== (c == 10) || tick_1hz !== (c == 10)) begin n_fail++; $display("FAIL rollover_strobe cyc %0d got roll %b tick %b", c, rollover, tick_1hz); end
    end
    n_assert++; if ({hr, mn, sec} !== 24'h000000) begin n_fail++; $display("FAIL rollover_time got %h exp 000000", {hr, mn, sec}); end
    step();
    n_assert++; if (rollover !== 1'b0) begin n_fail++; $display("FAIL rollover_width got %b exp 0", rollover); end
  endtask

  task automatic test_set_coincident();
    run = 1'b0;
    do_clear();
    set_min = 1'b1;
    repeat (5) step();
    set_min = 1'b0;
    run = 1'b1;
    repeat (599) step();
    n_assert++; if ({hr, mn, sec} !== 24'h000559) begin n_fail++; $display("FAIL coinc_pre got %h exp 000559", {hr, mn, sec}); end
    set_min = 1'b1;
    step();
    set_min = 1'b0;
    n_assert++; if ({hr, mn, sec} !== 24'h000600 || tick_1hz !== 1'b1) begin n_fail++; $display("FAIL coinc_set got %h tick %b exp 000600 1", {hr, mn, sec}, tick_1hz); end
  endtask
`else
  task automatic test_set_ignored();
    run = 1'b0;
    do_clear();
    set_min = 1'b1;
    set_hr  = 1'b1;
    repeat (5) step();
    set_min = 1'b0;
    set_hr  = 1'b0;
    n_assert++; if ({hr, mn, sec} !== 24'h000000) begin n_fail++; $display("FAIL set_ignored got %h exp 000000", {hr, mn, sec}); end
    run = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_sec_min_carry();
    test_hour_carry();
    test_run_pause();
    test_reset_clear_mid();
`ifdef TIME_KEEPER_SET_EN
    test_set_wrap();
    test_rollover();
    test_set_coincident();
`else
    test_set_ignored();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
